// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter: frame geometry and FSM encoding.
package i2s_pkg;

    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS  = 32;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int SLOT_W     = $clog2(SLOT_BITS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides Clk into sclk and flags the cycle before each sclk edge.
module i2s_clkgen #(
    parameter int SCLK_DIV = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic run,
    output logic sclk,
    output logic fall_stb
);

    localparam int CW = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] LAST    = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] RISE_AT = CW'(SCLK_DIV / 2 - 1);

    logic [CW-1:0] div_cnt;
    logic          rise_stb;

    assign rise_stb = run && (div_cnt == RISE_AT);
    assign fall_stb = run && (div_cnt == LAST);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            div_cnt <= '0;
        else if (!run || div_cnt == LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + CW'(1);
    end

    // sclk is registered so the codec sees a glitch-free clock.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            sclk <= 1'b0;
        else if (!run)
            sclk <= 1'b0;
        else if (rise_stb)
            sclk <= 1'b1;
        else if (fall_stb)
            sclk <= 1'b0;
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S stereo transmitter: one-entry sample buffer, per-frame shadow load, MSB-first serialiser.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int SCLK_DIV = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              en,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              sclk,
    output logic              lrclk,
    output logic              sdout,
    output logic              underrun
);

    localparam logic [SLOT_W-1:0] DW_POS = SLOT_W'(DATA_W);

    state_t             state, state_nxt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               run, fall_stb, wrap, load_evt, accept;
    logic               hold_full;
    logic [DATA_W-1:0]  hold_l, hold_r, shd_l, shd_r;
    logic [SLOT_W-1:0]  slot_pos;
    logic [DATA_W-1:0]  slot_word, slot_shift;

    assign run          = (state != IDLE);
    assign wrap         = fall_stb && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign sample_ready = !hold_full;
    assign accept       = sample_valid && !hold_full;
    assign lrclk        = bit_cnt[BIT_W-1];

    i2s_clkgen #(.SCLK_DIV(SCLK_DIV)) u_clkgen (
        .Clk      (Clk),
        .Reset    (Reset),
        .run      (run),
        .sclk     (sclk),
        .fall_stb (fall_stb)
    );

    // NOTE: defaults first, so no path through this block leaves a variable unassigned (no latch).
    always_comb begin
        state_nxt = state;
        load_evt  = 1'b0;
        case (state)
            IDLE: if (en) begin
                state_nxt = RUN;
                load_evt  = 1'b1;
            end
            RUN: begin
                if (!en) state_nxt = DRAIN;
                load_evt = wrap;
            end
            DRAIN: if (en) begin
                state_nxt = RUN;
                load_evt  = wrap;
            end else if (wrap) begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
            shd_l     <= '0;
            shd_r     <= '0;
            underrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            underrun <= load_evt && !hold_full;
            if (!run)
                bit_cnt <= '0;
            else if (fall_stb)
                bit_cnt <= bit_cnt + BIT_W'(1);
            if (load_evt) begin
                shd_l <= hold_full ? hold_l : '0;
                shd_r <= hold_full ? hold_r : '0;
            end
            // A load with an empty buffer still lets a same-cycle accept land for the next frame.
            if (load_evt && hold_full)
                hold_full <= 1'b0;
            else if (accept)
                hold_full <= 1'b1;
        end
    end

    // NOTE: pure data registers qualified by hold_full need no reset.
    always_ff @(posedge Clk) begin
        if (accept) begin
            hold_l <= sample_l;
            hold_r <= sample_r;
        end
    end

    // Slot position 0 is the I2S one-bit delay; positions past DATA_W pad with zeros.
    always_comb begin
        slot_pos   = bit_cnt[SLOT_W-1:0];
        slot_word  = bit_cnt[BIT_W-1] ? shd_r : shd_l;
        slot_shift = slot_word >> (DW_POS - slot_pos);
        sdout      = (slot_pos != '0 && slot_pos <= DW_POS) ? slot_shift[0] : 1'b0;
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: frame-bit scoreboard, handshake, underrun, drain and reset checks.
module tb_i2s_tx;

    localparam int DW  = 16;
    localparam int DIV = 16;
    localparam int FR  = 64 * DIV;

    typedef struct packed {
        logic lr;
        logic sd;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Reset, en, sample_valid;
    logic [DW-1:0] sample_l, sample_r;
    logic          sample_ready, sclk, lrclk, sdout, underrun;

    int   cyc = 0;
    int   n_checks = 0, n_pass = 0, n_fail = 0;
    int   base, base2, base3;
    int   exp_ur[$];
    int   ur_q[$];
    exp_t exp_q[$];
    logic armed;
    logic prev_sclk = 1'b0, prev_lr = 1'b0, prev_sd = 1'b0;
    logic idle_seen;

    i2s_tx #(.DATA_W(DW), .SCLK_DIV(DIV)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .en           (en),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sdout        (sdout),
        .underrun     (underrun)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        logic [DW-1:0] w;
        exp_t e;
        for (int b = 0; b < 64; b++) begin
            int p;
            p    = b % 32;
            e.lr = (b >= 32);
            w    = e.lr ? r : l;
            e.sd = (p >= 1 && p <= DW) ? w[DW-p] : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge Clk);
    endtask

    // Bit monitor: each sclk rise pops one expected {lrclk, sdout}; data may only move on sclk falls.
    always @(negedge Clk) begin
        prev_sclk <= sclk;
        prev_lr   <= lrclk;
        prev_sd   <= sdout;
        if (armed && !Reset) begin
            if (!prev_sclk && sclk) begin
                if (exp_q.size() == 0)
                    check("sb_unexpected_bit", 32'd1, 32'd0);
                else begin
                    check("sb_sdout", sdout, exp_q[0].sd);
                    check("sb_lrclk", lrclk, exp_q[0].lr);
                    void'(exp_q.pop_front());
                end
            end
            if (lrclk !== prev_lr || sdout !== prev_sd)
                check("edge_align", prev_sclk & ~sclk, 32'd1);
        end
        if (underrun === 1'b1) ur_q.push_back(cyc);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; en = 1'b0; sample_valid = 1'b0;
        sample_l = '0; sample_r = '0; armed = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_sclk", sclk, 0);
        check("rst_lrclk", lrclk, 0);
        check("rst_sdout", sdout, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", sample_ready, 1);
        Reset = 1'b0;
        @(negedge Clk);

        // Pair buffered before RUN entry, then two silent frames
        sample_l = 16'hA5F0; sample_r = 16'h8001; sample_valid = 1'b1;
        push_frame(16'hA5F0, 16'h8001);
        @(negedge Clk);
        check("b_accept_ready", sample_ready, 0);
        sample_valid = 1'b0; en = 1'b1; armed = 1'b1;
        push_frame('0, '0);
        push_frame('0, '0);
        @(negedge Clk);
        base = cyc;
        check("b_ready_after_load", sample_ready, 1);
        exp_ur.push_back(base + FR);
        exp_ur.push_back(base + 2 * FR);
        wait_until(base + 7);   check("sclk_low_7", sclk, 0);
        wait_until(base + 8);   check("sclk_rise_8", sclk, 1);
        wait_until(base + 15);  check("sclk_high_15", sclk, 1);
        wait_until(base + 16);  check("sclk_fall_16", sclk, 0);
        wait_until(base + 24);  check("sclk_rise_24", sclk, 1);
        wait_until(base + 511); check("lrclk_left_end", lrclk, 0);
        wait_until(base + 512); check("lrclk_right_start", lrclk, 1);
        wait_until(base + 1023); check("frame_end_sclk", sclk, 1);
        wait_until(base + 1024); check("frame_wrap_lrclk", lrclk, 0);

        // Valid held high across frames 3..4 loads
        wait_until(base + 2 * FR + 100);
        sample_l = 16'h1234; sample_r = 16'hFEDC; sample_valid = 1'b1;
        push_frame(16'h1234, 16'hFEDC);
        push_frame(16'h1234, 16'hFEDC);
        push_frame(16'h1234, 16'hFEDC);
        @(negedge Clk);
        check("c_accept_now", sample_ready, 0);
        wait_until(base + 3 * FR - 1);   check("c_ready_before_l3", sample_ready, 0);
        wait_until(base + 3 * FR);       check("c_ready_at_l3", sample_ready, 1);
        wait_until(base + 3 * FR + 1);   check("c_ready_after_l3", sample_ready, 0);
        wait_until(base + 3 * FR + 512); check("c_ready_mid", sample_ready, 0);
        wait_until(base + 4 * FR);       check("c_ready_at_l4", sample_ready, 1);
        wait_until(base + 4 * FR + 1);   check("c_ready_after_l4", sample_ready, 0);
        wait_until(base + 4 * FR + 10);
        sample_valid = 1'b0;
        push_frame('0, '0);
        push_frame('0, '0);
        exp_ur.push_back(base + 6 * FR);
        wait_until(base + 5 * FR);       check("c_ready_at_l5", sample_ready, 1);

        // Valid arrives exactly on a load with the buffer empty
        wait_until(base + 7 * FR - 1);
        sample_l = 16'h7FFF; sample_r = 16'h0001; sample_valid = 1'b1;
        push_frame(16'h7FFF, 16'h0001);
        exp_ur.push_back(base + 7 * FR);
        @(negedge Clk);
        check("d_accept_on_load", sample_ready, 0);
        sample_valid = 1'b0;
        push_frame('0, '0);
        exp_ur.push_back(base + 9 * FR);
        wait_until(base + 8 * FR); check("d_ready_at_l8", sample_ready, 1);

        // en dropped at bit 20: frame completes, then IDLE
        wait_until(base + 9 * FR + 325);
        en = 1'b0;
        wait_until(base + 10 * FR - 1);
        check("e_last_bit_sclk", sclk, 1);
        check("e_last_bit_lrclk", lrclk, 1);
        wait_until(base + 10 * FR);
        check("e_idle_sclk", sclk, 0);
        check("e_idle_lrclk", lrclk, 0);
        check("e_idle_sdout", sdout, 0);
        idle_seen = 1'b0;
        repeat (64) begin
            @(negedge Clk);
            if (sclk !== 1'b0 || lrclk !== 1'b0 || sdout !== 1'b0) idle_seen = 1'b1;
        end
        check("e_idle_quiet", idle_seen, 0);
        check("e_sb_drained", exp_q.size(), 0);
        armed = 1'b0;

        // Reset mid-frame at bit 40
        sample_l = 16'h0F0F; sample_r = 16'h0100; sample_valid = 1'b1;
        push_frame(16'h0F0F, 16'h0100);
        @(negedge Clk);
        check("f_accept", sample_ready, 0);
        sample_valid = 1'b0; en = 1'b1; armed = 1'b1;
        @(negedge Clk);
        base2 = cyc;
        wait_until(base2 + 652);
        check("f_pre_sclk", sclk, 1);
        check("f_pre_lrclk", lrclk, 1);
        check("f_pre_sdout", sdout, 1);
        armed = 1'b0;
        exp_q.delete();
        #2 Reset = 1'b1;
        #1;
        check("f_rst_sclk", sclk, 0);
        check("f_rst_lrclk", lrclk, 0);
        check("f_rst_sdout", sdout, 0);
        check("f_rst_ready", sample_ready, 1);
        check("f_rst_underrun", underrun, 0);
        @(negedge Clk);
        Reset = 1'b0;
        push_frame('0, '0);
        armed = 1'b1;
        @(negedge Clk);
        base3 = cyc;
        exp_ur.push_back(base3);
        check("f_restart_lrclk", lrclk, 0);
        check("f_restart_sclk", sclk, 0);
        wait_until(base3 + 8);
        check("f_restart_rise", sclk, 1);
        check("f_restart_bit0_lr", lrclk, 0);
        wait_until(base3 + 100);
        sample_l = 16'hC3A5; sample_r = 16'h5A3C; sample_valid = 1'b1;
        push_frame(16'hC3A5, 16'h5A3C);
        @(negedge Clk);
        check("f_accept2", sample_ready, 0);
        sample_valid = 1'b0;
        wait_until(base3 + FR + 10);
        en = 1'b0;
        wait_until(base3 + 2 * FR + 20);
        check("f_idle_sclk", sclk, 0);
        check("f_sb_drained", exp_q.size(), 0);
        armed = 1'b0;

        check("ur_count", ur_q.size(), exp_ur.size());
        for (int i = 0; i < exp_ur.size() && i < ur_q.size(); i++)
            check("ur_cycle", ur_q[i], exp_ur[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width per channel (at most 31).
REQ-002 SHALL have parameter SCLK_DIV, default 16, Clk cycles per SCLK period (even, at least 4).
REQ-003 SHALL have port Clk, input, 1 bit: single system clock (50 MHz); all logic on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: run request.
REQ-006 SHALL have port sample_l, input, DATA_W bits: left sample, two's complement.
REQ-007 SHALL have port sample_r, input, DATA_W bits: right sample, two's complement.
REQ-008 SHALL have port sample_valid, input, 1 bit: producer offers the stereo pair.
REQ-009 SHALL have port sample_ready, output, 1 bit: holding buffer empty, pair is accepted.
REQ-010 SHALL have port sclk, output, 1 bit: I2S bit clock to codec.
REQ-011 SHALL have port lrclk, output, 1 bit: word select; 0 = left, 1 = right.
REQ-012 SHALL have port sdout, output, 1 bit: serial data to codec DIN.
REQ-013 SHALL have port underrun, output, 1 bit: one-Clk pulse when a frame starts with no sample buffered.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN.
- IDLE -> RUN when en=1.
- RUN -> DRAIN when en=0.
- DRAIN -> RUN when en=1.
- DRAIN -> IDLE at the end of the current frame (bit_cnt 63 to 0 boundary).
REQ-015 In IDLE, sclk, lrclk and sdout SHALL be held 0, and div_cnt and bit_cnt SHALL be held 0.
REQ-016 In RUN and DRAIN, div_cnt SHALL count 0..SCLK_DIV-1 and wrap.
- sclk is 0 while div_cnt < SCLK_DIV/2, else 1.
- Falling edge of sclk occurs at the wrap.
REQ-017 At each sclk falling edge, 6-bit bit_cnt SHALL increment mod 64.
- lrclk = bit_cnt[5].
- lrclk and sdout change only at sclk falling edges.
REQ-018 Slot position p = bit_cnt[4:0].
- sdout = 0 at p=0.
- sdout = data bit DATA_W-p (MSB first) for p = 1..DATA_W.
- sdout = 0 for p > DATA_W.
- This gives standard I2S one-bit delay.
REQ-019 The frame-load event SHALL occur on the RUN entry cycle and on each 63-to-0 wrap while in RUN.
- If the buffer is full: copy the pair to the shadow shifter and empty the buffer.
- If the buffer is empty: load zeros into the shadow shifter and pulse underrun for 1 cycle.
REQ-020 The wrap that ends DRAIN SHALL NOT perform a load and SHALL NOT pulse underrun.
REQ-021 Handshake:
- Accept when sample_valid & sample_ready; the pair is latched into a one-entry buffer.
- sample_ready = buffer empty, in any state.
REQ-022 When accept and frame-load coincide with the buffer empty, the load SHALL use zeros (underrun) and the accepted pair SHALL remain buffered for the next frame.
REQ-023 After a load, sample_ready SHALL rise on the following cycle.
REQ-024 Samples SHALL be transmitted bit-exact with no sign extension; padding bits are 0.
REQ-025 Frame length SHALL be 64*SCLK_DIV Clk cycles (1024 at defaults, 48.83 kHz from 50 MHz).

Reset
REQ-026 On Reset the block SHALL immediately enter IDLE, asynchronously.
REQ-027 On Reset, outputs SHALL go to: sclk=0, lrclk=0, sdout=0, underrun=0, sample_ready=1.
REQ-028 On Reset, the buffer SHALL be emptied, the shadow shifter cleared, and div_cnt and bit_cnt set to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no further sdout bits.

Structure
REQ-030 Package i2s_pkg SHALL hold the FSM state enum and constants FRAME_BITS=64 and SLOT_BITS=32.
REQ-031 Sub-module i2s_clkgen SHALL implement div_cnt and the sclk, fall-strobe and rise-strobe generation; i2s_tx instantiates it once.

Verification
REQ-032 Reset, en=1, pair L=16'hA5F0, R=16'h8001 presented before RUN entry -> bits p=1..16 of the left slot are A5F0 MSB first; the right slot is 8001; underrun stays 0.
REQ-033 en=1, no sample_valid -> underrun pulses once per 1024 cycles; sdout stays constant 0; sclk period is 16 cycles, with 8 low then 8 high.
REQ-034 Valid held high continuously -> exactly one accept per frame, asserted cycle after each load; ready low at all other times.
REQ-035 Valid rises on the frame-load cycle with the buffer empty -> that frame is silent with an underrun pulse; the pair is transmitted in the next frame.
REQ-036 en dropped at bit_cnt=20 -> frame completes through bit 63; then sclk, lrclk and sdout are 0 and the FSM is IDLE; no underrun pulse at the final wrap.
REQ-037 Reset pulsed at bit_cnt=40 -> same cycle sclk=0, lrclk=0, sdout=0, sample_ready=1; after release with en=1, a new frame starts at bit 0.
